// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode encodings and flag bit positions for the branch/jump resolver.
package brj_pkg;

  typedef enum logic [1:0] {BEQ = 2'd0, BNE = 2'd1, BLT = 2'd2, BGE = 2'd3} br_op_e;
  typedef enum logic [1:0] {J = 2'd0, JR = 2'd1, JAL = 2'd2, RET = 2'd3} jmp_op_e;

  localparam int FL_N = 1;
  localparam int FL_Z = 0;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage bus into the resolver: instruction/prediction in, redirect/link/RAS/counters out.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             valid;
  logic             stall;
  logic             kill;
  logic             branch;
  logic             jump;
  logic [1:0]       op_code;
  logic [1:0]       fl;
  logic [XLEN-1:0]  pc_4;
  logic [XLEN-1:0]  reg_a;
  logic [XLEN-1:0]  immi;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             lr_we;
  logic [XLEN-1:0]  lr_wdata;
  logic [XLEN-1:0]  ras_top;
  logic             ras_valid;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output valid, stall, kill, branch, jump, op_code, fl, pc_4, reg_a, immi,
           pred_taken, pred_target,
    input  redirect, redirect_pc, lr_we, lr_wdata, ras_top, ras_valid, br_count, mp_count
  );

  modport slave (
    input  valid, stall, kill, branch, jump, op_code, fl, pc_4, reg_a, immi,
           pred_taken, pred_target,
    output redirect, redirect_pc, lr_we, lr_wdata, ras_top, ras_valid, br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve_unit_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            valid_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && cnt_q != '0) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[ptr_q] <= push_data_i;
    end
  end

  // ptr points at the next free slot, so the top lives one below it
  assign top_idx = ptr_q - PW'(1);
  assign valid_o = (cnt_q != '0);
  assign top_o   = valid_o ? mem_q[top_idx] : '0;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: computes the real outcome, compares to the fetch prediction
// and issues a registered redirect, link write, RAS update and saturating perf counters.
module branch_resolve_unit
  import brj_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  br_op_e          bop;
  jmp_op_e         jop;
  logic            act, taken, mispredict, push, pop;
  logic [XLEN-1:0] target, next_pc;

  logic             redirect_q, redirect_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             lr_we_q, lr_we_d;
  logic [XLEN-1:0]  lr_wdata_q, lr_wdata_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  assign bop = br_op_e'(bus.op_code);
  assign jop = jmp_op_e'(bus.op_code);

  // jump takes priority when both branch and jump are flagged
  always_comb begin
    taken  = 1'b0;
    target = bus.pc_4 + bus.reg_a;
    if (bus.jump) begin
      taken = 1'b1;
      case (jop)
        J, JAL:  target = bus.immi;
        default: target = bus.reg_a << 2;
      endcase
    end else begin
      case (bop)
        BEQ:     taken =  bus.fl[FL_Z];
        BNE:     taken = ~bus.fl[FL_Z];
        BLT:     taken =  bus.fl[FL_N];
        default: taken = ~bus.fl[FL_N];
      endcase
    end
  end

  assign act        = bus.valid & ~bus.kill & ~bus.stall & (bus.branch | bus.jump);
  assign next_pc    = taken ? target : bus.pc_4;
  assign mispredict = act & ((taken != bus.pred_taken) |
                             (taken & (bus.pred_target != target)));
  assign push       = act & bus.jump & (jop == JAL);
  assign pop        = act & bus.jump & (jop == RET);

  always_comb begin
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    lr_we_d       = lr_we_q;
    lr_wdata_d    = lr_wdata_q;
    br_cnt_d      = br_cnt_q;
    mp_cnt_d      = mp_cnt_q;
    // stall freezes everything, so a pending pulse stretches until it drops
    if (!bus.stall) begin
      redirect_d = mispredict;
      lr_we_d    = push;
      if (act) begin
        redirect_pc_d = next_pc;
        lr_wdata_d    = bus.pc_4;
        if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (mispredict && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      lr_we_q       <= 1'b0;
      lr_wdata_q    <= '0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      lr_we_q       <= lr_we_d;
      lr_wdata_q    <= lr_wdata_d;
      br_cnt_q      <= br_cnt_d;
      mp_cnt_q      <= mp_cnt_d;
    end
  end

  ras_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (bus.pc_4),
    .top_o       (bus.ras_top),
    .valid_o     (bus.ras_valid)
  );

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.lr_we       = lr_we_q;
  assign bus.lr_wdata    = lr_wdata_q;
  assign bus.br_count    = br_cnt_q;
  assign bus.mp_count    = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: a queue-based outcome model checked every cycle, plus hand-computed literals.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bm ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(4))  bs ();

  // narrow-counter copy sees identical stimulus
  assign bs.valid       = bm.valid;
  assign bs.stall       = bm.stall;
  assign bs.kill        = bm.kill;
  assign bs.branch      = bm.branch;
  assign bs.jump        = bm.jump;
  assign bs.op_code     = bm.op_code;
  assign bs.fl          = bm.fl;
  assign bs.pc_4        = bm.pc_4;
  assign bs.reg_a       = bm.reg_a;
  assign bs.immi        = bm.immi;
  assign bs.pred_taken  = bm.pred_taken;
  assign bs.pred_target = bm.pred_target;

  branch_resolve_unit #(.XLEN(32), .RAS_DEPTH(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bm));
  branch_resolve_unit #(.XLEN(32), .RAS_DEPTH(4), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bs));

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  logic        m_redir, m_lrwe;
  logic [31:0] m_rpc, m_lrwd;
  logic [31:0] m_ras[$];
  int          m_br, m_mp, m_br4, m_mp4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  task automatic model_reset();
    m_redir = 0; m_lrwe = 0; m_rpc = 0; m_lrwd = 0;
    m_ras.delete();
    m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
  endtask

  task automatic model_step();
    bit tk, mp;
    logic [31:0] tg;
    int op;
    if (bm.stall) return;
    if (!(bm.valid && !bm.kill && (bm.branch || bm.jump))) begin
      m_redir = 0; m_lrwe = 0;
      return;
    end
    op = int'(bm.op_code);
    if (bm.jump) begin
      tk = 1;
      tg = (op == 0 || op == 2) ? bm.immi : (bm.reg_a << 2);
    end else begin
      tg = bm.pc_4 + bm.reg_a;
      case (op)
        0: tk = bm.fl[0];
        1: tk = !bm.fl[0];
        2: tk = bm.fl[1];
        default: tk = !bm.fl[1];
      endcase
    end
    mp = (tk != bm.pred_taken) || (tk && bm.pred_target != tg);
    m_redir = mp;
    m_rpc   = tk ? tg : bm.pc_4;
    m_lrwe  = bm.jump && op == 2;
    m_lrwd  = bm.pc_4;
    if (bm.jump && op == 2) begin
      m_ras.push_back(bm.pc_4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (bm.jump && op == 3 && m_ras.size() > 0) void'(m_ras.pop_back());
    if (m_br < 65535) m_br++;
    if (m_br4 < 15) m_br4++;
    if (mp && m_mp < 65535) m_mp++;
    if (mp && m_mp4 < 15) m_mp4++;
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("redirect", 32'(bm.redirect), 32'(m_redir));
      if (m_redir) chk("redirect_pc", bm.redirect_pc, m_rpc);
      chk("lr_we", 32'(bm.lr_we), 32'(m_lrwe));
      if (m_lrwe) chk("lr_wdata", bm.lr_wdata, m_lrwd);
      chk("ras_top", bm.ras_top, m_top());
      chk("ras_valid", 32'(bm.ras_valid), 32'(m_ras.size() > 0));
      chk("br_count", 32'(bm.br_count), 32'(m_br));
      chk("mp_count", 32'(bm.mp_count), 32'(m_mp));
      chk("br_count4", 32'(bs.br_count), 32'(m_br4));
      chk("mp_count4", 32'(bs.mp_count), 32'(m_mp4));
    end
  end

  task automatic drive(input bit br, input bit jp, input logic [1:0] op, input logic [1:0] fl,
                       input logic [31:0] pc4, input logic [31:0] ra, input logic [31:0] imm,
                       input bit pt, input logic [31:0] ptg, input bit st, input bit kl);
    bm.valid = 1; bm.branch = br; bm.jump = jp; bm.op_code = op; bm.fl = fl;
    bm.pc_4 = pc4; bm.reg_a = ra; bm.immi = imm; bm.pred_taken = pt; bm.pred_target = ptg;
    bm.stall = st; bm.kill = kl;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic go_idle();
    bm.valid = 0; bm.stall = 0; bm.kill = 0; bm.branch = 0; bm.jump = 0;
  endtask

  task automatic do_reset();
    cmp_en = 0;
    go_idle();
    rst = 1;
    model_reset();
    #2 rst = 0;
    cmp_en = 1;
  endtask

  task automatic vec(input string nm, input bit br, input bit jp, input logic [1:0] op,
                     input logic [1:0] fl, input logic [31:0] pc4, input logic [31:0] ra,
                     input logic [31:0] imm, input bit pt, input logic [31:0] ptg,
                     input bit exp_r, input logic [31:0] exp_pc);
    drive(br, jp, op, fl, pc4, ra, imm, pt, ptg, 0, 0);
    step();
    chk({nm, "_redirect"}, 32'(bm.redirect), 32'(exp_r));
    if (exp_r) chk({nm, "_pc"}, bm.redirect_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    go_idle();
    bm.op_code = 0; bm.fl = 0; bm.pc_4 = 0; bm.reg_a = 0; bm.immi = 0;
    bm.pred_taken = 0; bm.pred_target = 0;
    model_reset();
    #3;
    chk("rst_redirect", 32'(bm.redirect), 0);
    chk("rst_redirect_pc", bm.redirect_pc, 0);
    chk("rst_lr_we", 32'(bm.lr_we), 0);
    chk("rst_lr_wdata", bm.lr_wdata, 0);
    chk("rst_ras_top", bm.ras_top, 0);
    chk("rst_ras_valid", 32'(bm.ras_valid), 0);
    chk("rst_br_count", 32'(bm.br_count), 0);
    chk("rst_mp_count", 32'(bm.mp_count), 0);
    @(negedge clk); #1;
    do_reset();

    // BEQ taken but predicted not-taken
    drive(1, 0, 2'd0, 2'b01, 32'h100, 32'h20, 0, 0, 0, 0, 0);
    step();
    chk("beq_redirect", 32'(bm.redirect), 1);
    chk("beq_pc", bm.redirect_pc, 32'h120);
    chk("beq_mp", 32'(bm.mp_count), 1);
    go_idle(); step();
    chk("beq_pulse_end", 32'(bm.redirect), 0);

    do_reset();
    drive(1, 0, 2'd1, 2'b01, 32'h100, 32'h20, 0, 0, 0, 0, 0);
    step();
    chk("bne_redirect", 32'(bm.redirect), 0);
    chk("bne_br", 32'(bm.br_count), 1);
    chk("bne_mp", 32'(bm.mp_count), 0);

    vec("blt_neg", 1, 0, 2'd2, 2'b10, 32'h1000, 32'hFFFF_FFF0, 0, 1, 32'hFF0, 0, 0);
    vec("bge_nt",  1, 0, 2'd3, 2'b10, 32'h1000, 32'h40, 0, 1, 32'h1040, 1, 32'h1000);
    vec("blt_nt",  1, 0, 2'd2, 2'b00, 32'h1000, 32'h40, 0, 0, 0, 0, 0);
    vec("j_tgt",   0, 1, 2'd0, 2'b00, 32'h10, 0, 32'h8000, 1, 32'h7000, 1, 32'h8000);
    vec("jr_wrap", 0, 1, 2'd1, 2'b00, 32'h10, 32'hC000_0001, 0, 0, 0, 1, 32'h4);
    vec("br_jp",   1, 1, 2'd0, 2'b00, 32'h10, 32'h8, 32'h2000, 1, 32'h2000, 0, 0);

    do_reset();
    drive(0, 1, 2'd2, 2'b00, 32'h84, 0, 32'h400, 1, 32'h400, 0, 0);
    step();
    chk("jal_redirect", 32'(bm.redirect), 0);
    chk("jal_lr_we", 32'(bm.lr_we), 1);
    chk("jal_lr_wdata", bm.lr_wdata, 32'h84);
    chk("jal_ras_top", bm.ras_top, 32'h84);
    chk("jal_ras_valid", 32'(bm.ras_valid), 1);
    drive(0, 1, 2'd3, 2'b00, 32'h404, 32'h21, 0, 0, 0, 0, 0);
    step();
    chk("ret_redirect", 32'(bm.redirect), 1);
    chk("ret_pc", bm.redirect_pc, 32'h84);
    chk("ret_lr_we", 32'(bm.lr_we), 0);
    chk("ret_ras_valid", 32'(bm.ras_valid), 0);

    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 2'd2, 2'b00, 32'(k * 16), 0, 32'h900, 1, 32'h900, 0, 0);
      step();
    end
    chk("ras_full_top", bm.ras_top, 32'h50);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] exp_top;
      exp_top = (k < 3) ? 32'(32'h40 - k * 16) : 32'h0;
      drive(0, 1, 2'd3, 2'b00, 32'h200, 32'h14, 0, 1, 32'h50, 0, 0);
      step();
      chk("ras_pop_top", bm.ras_top, exp_top);
      chk("ras_pop_valid", 32'(bm.ras_valid), 32'(k < 3));
    end

    do_reset();
    drive(1, 0, 2'd0, 2'b01, 32'h200, 32'h10, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 2'd1, 2'b00, 32'h300, 32'h4, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_redirect", 32'(bm.redirect), 1);
      chk("stall_pc", bm.redirect_pc, 32'h210);
      chk("stall_br", 32'(bm.br_count), 1);
    end
    drive(1, 0, 2'd1, 2'b00, 32'h300, 32'h4, 0, 0, 0, 0, 1);
    step();
    chk("kill_redirect", 32'(bm.redirect), 0);
    chk("kill_br", 32'(bm.br_count), 1);
    drive(1, 0, 2'd1, 2'b00, 32'h300, 32'h4, 0, 0, 0, 1, 1);
    step();
    chk("kill_stall_redirect", 32'(bm.redirect), 0);

    // reset lands between edges while a redirect/link pulse is live
    do_reset();
    drive(0, 1, 2'd2, 2'b00, 32'h44, 0, 32'h600, 0, 0, 0, 0);
    step();
    chk("pre_rst_redirect", 32'(bm.redirect), 1);
    cmp_en = 0;
    rst = 1;
    #1;
    chk("midrst_redirect", 32'(bm.redirect), 0);
    chk("midrst_lr_we", 32'(bm.lr_we), 0);
    chk("midrst_br", 32'(bm.br_count), 0);
    chk("midrst_ras_valid", 32'(bm.ras_valid), 0);
    chk("midrst_ras_top", bm.ras_top, 0);
    @(negedge clk); #1;
    do_reset();

    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 2'd0, 2'b01, 32'h100, 32'h8, 0, k[0], 32'h108, 0, 0);
      step();
    end
    go_idle(); step();
    chk("sat_br4", 32'(bs.br_count), 15);
    chk("sat_mp4", 32'(bs.mp_count), 10);
    chk("sat_br16", 32'(bm.br_count), 20);
    chk("sat_mp16", 32'(bm.mp_count), 10);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
